rx_frontend: RTL and testbench

UART receive front-end: deserialises frames from the asynchronous `uart_rx_i` line into a data byte, flagging parity and framing errors. It is the receive counterpart of the UART transmit front-end and shares its control-register fields, so one configuration drives both directions. It sits between the UART pad and the register/Wishbone layer, which consumes `output_valid_o`, `dr_o` and the error flags.

---
 rtl/rx_frontend.sv | 126 ++++++++++++
 tb/tb_rx_frontend.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rx_frontend.sv
// rx_frontend: UART receive front-end with mid-bit sampling from a fractional baud accumulator.
// Produces one data byte per frame, flagging parity and framing errors.
module rx_frontend (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cr_acc_incr_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        uart_rx_i,
  output logic [7:0]  dr_o,
  output logic        output_valid_o,
  output logic        parity_error_o,
  output logic        frame_error_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic [15:0] acc_q, acc_d;
  logic [16:0] sum;
  logic        rx_s, fall, ovf;
  logic        ds_q, ds_d, s_q, s_d, par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, stop_q, stop_d;
  logic [1:0]  p_q, p_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  dr_q, dr_d, dro_d;
  logic        valid_d, pe_d, fe_d;
  // sync_q[1] is the synchronised line, sync_q[2] its previous value
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign sum  = {1'b0, acc_q} + {1'b0, cr_acc_incr_i};
  assign ovf  = sum[16];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      sync_q         <= 3'b111;
      acc_q          <= '0;
      ds_q           <= 1'b0;
      p_q            <= '0;
      s_q            <= 1'b0;
      par_q          <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      stop_q         <= 1'b0;
      idx_q          <= '0;
      dr_q           <= '0;
      dr_o           <= '0;
      output_valid_o <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= {sync_q[1:0], uart_rx_i};
      acc_q          <= acc_d;
      ds_q           <= ds_d;
      p_q            <= p_d;
      s_q            <= s_d;
      par_q          <= par_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      stop_q         <= stop_d;
      idx_q          <= idx_d;
      dr_q           <= dr_d;
      dr_o           <= dro_d;
      output_valid_o <= valid_d;
      parity_error_o <= pe_d;
      frame_error_o  <= fe_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = sum[15:0];
    ds_d    = ds_q;
    p_d     = p_q;
    s_d     = s_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    dro_d   = dr_o;
    valid_d = 1'b0;
    pe_d    = parity_error_o;
    fe_d    = frame_error_o;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        acc_d   = 16'h8000;
        ds_d    = cr_ds_i;
        p_d     = cr_p_i;
        s_d     = cr_s_i;
        par_d   = cr_p_i[0];
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        idx_d   = '0;
        dr_d    = '0;
      end
      START: if (ovf) state_d = rx_s ? IDLE : DATA;
      DATA: if (ovf) begin
        dr_d[idx_q] = rx_s;
        par_d       = par_q ^ rx_s;
        idx_d       = idx_q + 3'd1;
        if (idx_q == {2'b11, ds_q}) begin
          state_d = (p_q != 2'b00) ? PARITY : STOP;
          stop_d  = s_q;
        end
      end
      PARITY: if (ovf) begin
        perr_d  = rx_s ^ par_q;
        state_d = STOP;
      end
      STOP: if (ovf) begin
        ferr_d = ferr_q | ~rx_s;
        stop_d = 1'b0;
        if (!stop_q) begin
          state_d = IDLE;
          valid_d = 1'b1;
          dro_d   = dr_q;
          pe_d    = perr_q;
          fe_d    = ferr_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rx_frontend.sv
// tb_rx_frontend: directed and randomised UART frames checked against a frame-level reference model.
module tb_rx_frontend;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] cr_acc_incr_i = 16'h1000;
  logic        cr_ds_i = 1'b1;
  logic [1:0]  cr_p_i = 2'b00;
  logic        cr_s_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic [7:0]  dr_o;
  logic        output_valid_o, parity_error_o, frame_error_o;

  typedef struct {int e; logic [7:0] d; logic pe; logic fe;} pulse_t;
  pulse_t q[$];
  int edge_n = 0, n_chk = 0, n_fail = 0, last_low = 0;
  logic [15:0] incr_t [3] = '{16'h1000, 16'h0800, 16'h2000};

  rx_frontend dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cr_acc_incr_i(cr_acc_incr_i), .cr_ds_i(cr_ds_i),
    .cr_p_i(cr_p_i), .cr_s_i(cr_s_i), .uart_rx_i(uart_rx_i), .dr_o(dr_o),
    .output_valid_o(output_valid_o), .parity_error_o(parity_error_o), .frame_error_o(frame_error_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_n++;
  // Every cycle the pulse is high is logged with the edge that registered it
  always @(negedge clk_i) if (output_valid_o === 1'b1) q.push_back('{edge_n, dr_o, parity_error_o, frame_error_o});

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int cyc);
    uart_rx_i = b;
    repeat (cyc) @(posedge clk_i);
    #1;
  endtask

  function automatic logic par_bit(input logic [7:0] dm, input logic [1:0] p);
    logic odd_ones = ($countones(dm) % 2) == 1;
    return (p == 2'b10) ? odd_ones : !odd_ones;
  endfunction

  task automatic send(input logic [7:0] d, input logic ds, input logic [1:0] p, input logic s,
                      input logic [15:0] incr, input logic flip, input logic stop_v, input logic scr);
    int per = 65536 / int'(incr);
    logic [7:0] dm = ds ? d : {1'b0, d[6:0]};
    cr_acc_incr_i = incr; cr_ds_i = ds; cr_p_i = p; cr_s_i = s;
    last_low = edge_n + 1;
    drive(1'b0, per);
    if (scr) begin cr_ds_i = ~ds; cr_p_i = p + 2'd1; cr_s_i = ~s; end
    for (int i = 0; i < (ds ? 8 : 7); i++) drive(dm[i], per);
    if (p != 2'b00) drive(par_bit(dm, p) ^ flip, per);
    drive(stop_v, per);
    if (s) drive(stop_v, per);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic ds, input logic [1:0] p,
                              input logic s, input logic [15:0] incr, input logic flip, input logic stop_v,
                              input int low);
    int per = 65536 / int'(incr);
    int nb = 1 + (ds ? 8 : 7) + ((p != 2'b00) ? 1 : 0) + (s ? 2 : 1);
    pulse_t r;
    for (int i = 0; i < 200 && q.size() == 0; i++) @(posedge clk_i);
    #1;
    chk({tag, ".seen"}, 32'(q.size() > 0), 32'd1);
    if (q.size() == 0) return;
    r = q.pop_front();
    chk({tag, ".when"}, r.e, low + 2 + per / 2 + per * (nb - 1));
    chk({tag, ".dr"}, r.d, ds ? d : {1'b0, d[6:0]});
    chk({tag, ".perr"}, r.pe, (p != 2'b00) && flip);
    chk({tag, ".ferr"}, r.fe, !stop_v);
  endtask

  initial begin
    logic [7:0] d;
    logic ds, s, flip, stop_v, scr;
    logic [1:0] p;
    logic [15:0] incr;
    int l1, l2, e1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.dr", dr_o, 8'h00);
    chk("rst.valid", output_valid_o, 1'b0);
    chk("rst.perr", parity_error_o, 1'b0);
    chk("rst.ferr", frame_error_o, 1'b0);
    rst_ni = 1'b1;
    drive(1'b1, 10);

    send(8'hA5, 1, 2'b00, 0, 16'h1000, 0, 1, 0);
    expect_frame("8n1_a5", 8'hA5, 1, 2'b00, 0, 16'h1000, 0, 1, last_low);
    drive(1'b1, 20);
    chk("8n1_a5.single", q.size(), 0);

    send(8'h53, 0, 2'b10, 1, 16'h1000, 0, 1, 0);
    expect_frame("7e2_ok", 8'h53, 0, 2'b10, 1, 16'h1000, 0, 1, last_low);
    drive(1'b1, 16);
    send(8'h53, 0, 2'b10, 1, 16'h1000, 1, 1, 0);
    expect_frame("7e2_bad", 8'h53, 0, 2'b10, 1, 16'h1000, 1, 1, last_low);
    drive(1'b1, 16);

    send(8'h00, 1, 2'b01, 0, 16'h1000, 0, 0, 0);
    expect_frame("8o1_brk", 8'h00, 1, 2'b01, 0, 16'h1000, 0, 0, last_low);
    drive(1'b0, 400);
    chk("brk.nostart", q.size(), 0);
    drive(1'b1, 20);

    drive(1'b0, 3);
    drive(1'b1, 300);
    chk("glitch.none", q.size(), 0);

    send(8'h12, 1, 2'b00, 0, 16'h1000, 0, 1, 0);
    l1 = last_low;
    send(8'h34, 1, 2'b00, 0, 16'h1000, 0, 1, 0);
    l2 = last_low;
    if (q.size() > 0) e1 = q[0].e; else e1 = 0;
    if (q.size() > 1) chk("b2b.gap", q[1].e - e1, 160);
    else chk("b2b.count", q.size(), 2);
    expect_frame("b2b_12", 8'h12, 1, 2'b00, 0, 16'h1000, 0, 1, l1);
    expect_frame("b2b_34", 8'h34, 1, 2'b00, 0, 16'h1000, 0, 1, l2);
    drive(1'b1, 16);

    send(8'hC3, 1, 2'b10, 0, 16'h1000, 1, 0, 0);
    expect_frame("8e1_err", 8'hC3, 1, 2'b10, 0, 16'h1000, 1, 0, last_low);
    drive(1'b1, 16);

    cr_acc_incr_i = 16'h1000; cr_ds_i = 1; cr_p_i = 2'b00; cr_s_i = 0;
    drive(1'b0, 16);
    drive(1'b1, 16); drive(1'b0, 16); drive(1'b1, 16);
    drive(1'b1, 8);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst.dr", dr_o, 8'h00);
    chk("arst.valid", output_valid_o, 1'b0);
    chk("arst.perr", parity_error_o, 1'b0);
    chk("arst.ferr", frame_error_o, 1'b0);
    uart_rx_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drive(1'b1, 200);
    chk("arst.nopulse", q.size(), 0);
    send(8'h7E, 1, 2'b00, 0, 16'h1000, 0, 1, 0);
    expect_frame("after_rst", 8'h7E, 1, 2'b00, 0, 16'h1000, 0, 1, last_low);
    drive(1'b1, 16);

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      ds = 1'($urandom_range(0, 1));
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      incr = incr_t[$urandom_range(0, 2)];
      flip = 1'($urandom_range(0, 3) == 0);
      stop_v = 1'($urandom_range(0, 4) != 0);
      scr = 1'($urandom_range(0, 1));
      send(d, ds, p, s, incr, flip, stop_v, scr);
      expect_frame($sformatf("rnd%0d", k), d, ds, p, s, incr, flip, stop_v, last_low);
      drive(1'b1, 65536 / int'(incr));
    end
    chk("end.noextra", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
